// File: rtl/seg_scan_mux.sv
// Shifts converter segment patterns into an N-digit buffer and scans it onto a shared segment
// bus with one-hot digit enables and a blanking gap. Optional dimming under SEG_SCAN_DIM_EN.
module seg_scan_mux #(
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DRIVE_CYC  = 1000,
    parameter int unsigned BLANK_CYC  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [BYTE_W-1:0]     seg_in,
    input  logic                  seg_ud,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0]            bright,
`endif
    output logic [BYTE_W-1:0]     seg_pins,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame
);

    localparam int unsigned MAX_CYC = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC);
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {StBlank, StDrive} state_e;

    state_e                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [BYTE_W-1:0]       r_buf [NUM_DIGITS];
    logic [BYTE_W-1:0]       r_seg_pins;
    logic [NUM_DIGITS-1:0]   r_dig_sel;
    logic                    r_frame;

    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [IDX_W-1:0]        w_idx_next;
    logic                    w_on_entry;
    logic                    w_on_hold;

    assign w_onehot   = NUM_DIGITS'(1) << r_idx;
    assign w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

`ifdef SEG_SCAN_DIM_EN
    logic [3:0]  r_bright;
    logic [31:0] w_lim_entry;
    logic [31:0] w_lim_hold;

    // Lit window is the first ((bright+1)*DRIVE_CYC)/16 cycles of each DRIVE phase.
    assign w_lim_entry = ((32'(bright) + 32'd1) * 32'(DRIVE_CYC)) >> 4;
    assign w_lim_hold  = ((32'(r_bright) + 32'd1) * 32'(DRIVE_CYC)) >> 4;
    assign w_on_entry  = (w_lim_entry != 32'd0);
    assign w_on_hold   = ((32'(r_cnt) + 32'd1) < w_lim_hold);
`else
    assign w_on_entry  = 1'b1;
    assign w_on_hold   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) r_buf[k] <= '0;
        end else if (seg_ud) begin
            for (int k = NUM_DIGITS - 1; k > 0; k--) r_buf[k] <= r_buf[k-1];
            r_buf[0] <= seg_in;
        end
    end

    // Outputs are loaded from the state being entered so they line up with the FSM phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StBlank;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_dig_sel  <= '0;
            r_seg_pins <= '0;
            r_frame    <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
            r_bright   <= '0;
`endif
        end else if (!en) begin
            r_dig_sel  <= '0;
            r_seg_pins <= '0;
            r_frame    <= 1'b0;
        end else begin
            r_dig_sel  <= '0;
            r_seg_pins <= '0;
            r_frame    <= 1'b0;
            unique case (r_state)
                StBlank: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= StDrive;
                        r_cnt   <= '0;
                        r_frame <= (r_idx == '0);
`ifdef SEG_SCAN_DIM_EN
                        r_bright <= bright;
`endif
                        if (w_on_entry) begin
                            r_dig_sel  <= w_onehot;
                            r_seg_pins <= r_buf[r_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StDrive: begin
                    if (r_cnt == DRIVE_LAST) begin
                        r_state <= StBlank;
                        r_cnt   <= '0;
                        r_idx   <= w_idx_next;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_on_hold) begin
                            r_dig_sel  <= w_onehot;
                            r_seg_pins <= r_buf[r_idx];
                        end
                    end
                end
            endcase
        end
    end

    assign seg_pins = r_seg_pins;
    assign dig_sel  = r_dig_sel;
    assign frame    = r_frame;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized bench for seg_scan_mux: outputs are predicted from a position-in-refresh-period model.
module tb_seg_scan_mux;

    localparam int unsigned BW  = 8;
    localparam int unsigned ND  = 4;
    localparam int unsigned DC  = 8;
    localparam int unsigned BC  = 2;
    localparam int unsigned PER = ND * (DC + BC);

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          en     = 1'b1;
    logic          seg_ud = 1'b0;
    logic [BW-1:0] seg_in = '0;
    logic [3:0]    bright = 4'hF;
    logic [BW-1:0] seg_pins;
    logic [ND-1:0] dig_sel;
    logic          frame;

    seg_scan_mux #(
        .BYTE_W    (BW),
        .NUM_DIGITS(ND),
        .DRIVE_CYC (DC),
        .BLANK_CYC (BC)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .seg_in  (seg_in),
        .seg_ud  (seg_ud),
`ifdef SEG_SCAN_DIM_EN
        .bright  (bright),
`endif
        .seg_pins(seg_pins),
        .dig_sel (dig_sel),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: n counts enabled clock edges since reset; position in the refresh period follows.
    int unsigned   n;
    logic [BW-1:0] mbuf [ND];
    logic [BW-1:0] e_seg;
    logic [ND-1:0] e_dig;
    logic          e_frame;

    int unsigned   cyc;
    int            last_frame;
    bit            chk_period;

    task automatic model_reset();
        n       = 0;
        e_seg   = '0;
        e_dig   = '0;
        e_frame = 1'b0;
        for (int k = 0; k < ND; k++) mbuf[k] = '0;
    endtask

    task automatic model_step(input logic en_v, input logic ud_v, input logic [BW-1:0] seg_v);
        int unsigned o, digit, ph;
        e_seg   = '0;
        e_dig   = '0;
        e_frame = 1'b0;
        if (en_v) begin
            n++;
            o     = (n + PER - BC) % PER;
            digit = o / (DC + BC);
            ph    = o % (DC + BC);
            if (ph < DC) begin
                e_dig   = ND'(1) << digit;
                e_seg   = mbuf[digit];
                e_frame = (digit == 0) && (ph == 0);
            end
        end
        if (ud_v) begin
            for (int k = ND - 1; k > 0; k--) mbuf[k] = mbuf[k-1];
            mbuf[0] = seg_v;
        end
    endtask

    task automatic compare_outputs();
        check("seg_pins", 32'(seg_pins), 32'(e_seg));
        check("dig_sel", 32'(dig_sel), 32'(e_dig));
        check("frame", 32'(frame), 32'(e_frame));
        check("onehot0", 32'($onehot0(dig_sel)), 32'd1);
    endtask

    // Called at a negedge: check, drive the next inputs, advance one clock.
    task automatic run_cycle(input logic en_v, input logic ud_v, input logic [BW-1:0] seg_v);
        compare_outputs();
        if (chk_period && frame) begin
            if (last_frame >= 0) check("frame_period", cyc - 32'(last_frame), PER);
            last_frame = int'(cyc);
        end
        en     = en_v;
        seg_ud = ud_v;
        seg_in = seg_v;
        @(posedge clk);
        model_step(en_v, ud_v, seg_v);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_random(input int unsigned cycles, input int unsigned en_pct,
                              input int unsigned ud_pct);
        for (int i = 0; i < int'(cycles); i++) begin
            run_cycle($urandom_range(99) < en_pct, $urandom_range(99) < ud_pct, BW'($urandom));
        end
    endtask

    initial begin
        cyc        = 0;
        last_frame = -1;
        chk_period = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_outputs();
        rst_n = 1'b1;

        // Directed shift order, then a free-running scan with frame-period tracking.
        run_cycle(1'b1, 1'b1, 8'h06);
        run_cycle(1'b1, 1'b1, 8'h5B);
        run_cycle(1'b1, 1'b1, 8'h4F);
        run_cycle(1'b1, 1'b1, 8'h66);
        chk_period = 1'b1;
        repeat (PER + 4) run_cycle(1'b1, 1'b0, 8'h00);
        run_cycle(1'b1, 1'b1, 8'h6D);
        repeat (PER) run_cycle(1'b1, 1'b0, 8'h00);
        run_random(200, 100, 5);
        chk_period = 1'b0;

        // Freeze bursts with strobes landing while disabled.
        for (int b = 0; b < 8; b++) begin
            run_random($urandom_range(30, 5), 100, 10);
            repeat (5) run_cycle(1'b0, $urandom_range(1), BW'($urandom));
        end
        run_random(600, 80, 30);

        // Asynchronous reset in the middle of activity.
        while (dig_sel == '0) run_cycle(1'b1, 1'b0, 8'h00);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back strobes, then heavy random traffic.
        run_cycle(1'b1, 1'b1, 8'h3F);
        run_cycle(1'b1, 1'b1, 8'h06);
        run_cycle(1'b1, 1'b1, 8'h5B);
        repeat (PER) run_cycle(1'b1, 1'b0, 8'h00);
        run_random(400, 95, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Downstream display stage for the UART-to-seven-segment path. Captures each segment pattern delivered by the character-to-segment converter on its one-cycle update strobe and shifts it into an N-digit display buffer, rightmost digit first. Time-multiplexes the buffer onto a shared segment bus with one-hot digit enables, inserting a blanking gap between digits to prevent ghosting.

## Interface
- BYTE_W, 8, segment pattern width (7 segments + DP)
- NUM_DIGITS, 4, display digits; must be ≥ 2
- DRIVE_CYC, 1000, clk cycles each digit is driven; must be ≥ 2
- BLANK_CYC, 16, clk cycles all digits are off between digits; must be ≥ 1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; low freezes scanning and blanks outputs
- seg_in  in  BYTE_W  segment pattern from the converter
- seg_ud  in  1  one-cycle strobe: seg_in valid
- seg_pins  out  BYTE_W  shared segment bus, active-high (1 = lit)
- dig_sel  out  NUM_DIGITS  one-hot digit enable, active-high
- frame  out  1  one-cycle pulse at the start of digit 0's DRIVE phase

## Operation
- Buffer: NUM_DIGITS × BYTE_W registers; digit 0 is rightmost.
- On seg_ud=1: buf[k] <= buf[k-1] for k ≥ 1, buf[0] <= seg_in. Accepted whenever out of reset, regardless of en and scan state. Every strobe is accepted; there is no back-pressure.
- Scan FSM states:
  - BLANK: dig_sel=0, seg_pins=0. Hold for BLANK_CYC cycles, then go to DRIVE.
  - DRIVE: dig_sel = one-hot(idx). seg_pins <= buf[idx] is reloaded every cycle. Hold for DRIVE_CYC cycles, then go to BLANK with idx <= idx+1.
- idx wraps from NUM_DIGITS-1 to 0.
- frame pulses on the first DRIVE cycle when idx=0.
- Phase counter is $clog2(max(DRIVE_CYC,BLANK_CYC)) bits. It is reset to 0 on every state change.
- en=0:
  - FSM, idx and counter hold their values.
  - dig_sel=0, seg_pins=0, frame=0.
  - On en returning high, the held state resumes from where it stopped.
- Reset values: dig_sel=0, seg_pins=0, frame=0, all buffer entries 0, state=BLANK, idx=0, counter=0.
- Reset mid-operation clears everything immediately (asynchronous). Any partially shifted data is lost.

## Timing
- All outputs are registered.
- Buffer write latency: a strobe at cycle t updates buf at t+1.
- Refresh latency: if idx currently drives the written digit, seg_pins shows the new pattern at t+2.
- Strobe during DRIVE of an affected digit: the pattern changes mid-drive. This is expected; no glitch protection is required.
- Back-to-back strobes on consecutive cycles each shift once, with no loss.
- Full refresh period = NUM_DIGITS × (DRIVE_CYC + BLANK_CYC) cycles.
- First DRIVE after reset begins BLANK_CYC cycles after rst_n deasserts (with en=1).
- dig_sel and seg_pins change on the same edge.
- dig_sel is never non-zero in BLANK.
- At most one dig_sel bit is ever high.

## Configuration
- SEG_SCAN_DIM_EN defined: adds input port bright (4 bits), for brightness control.
  - During DRIVE, dig_sel and seg_pins are active only while counter < ((bright+1)×DRIVE_CYC)>>4, and are 0 for the rest of the phase.
  - bright is sampled at the start of each DRIVE phase.
  - bright=15 gives full on.
- SEG_SCAN_DIM_EN undefined: the bright port is absent and DRIVE is full-on for all DRIVE_CYC cycles.

## Test plan
All scenarios use NUM_DIGITS=4, DRIVE_CYC=8, BLANK_CYC=2.

- Reset: hold rst_n=0 with en=1, then release → dig_sel=0 and seg_pins=0 for 2 cycles, then dig_sel=4'b0001, seg_pins=8'h00, frame=1 for one cycle.
- Shift order: strobe 8'h06, 8'h5B, 8'h4F, 8'h66 → scanning digits 0..3 shows 66, 4F, 5B, 06. A fifth strobe 8'h6D → digits show 6D, 66, 4F, 5B.
- Scan cadence: free-run → each dig_sel bit is high for exactly 8 cycles, followed by 2 cycles of 0. frame period = 40 cycles. Assert one-hot or zero every cycle.
- Freeze: drop en for 5 cycles mid-DRIVE of digit 2 → outputs are 0 throughout. On en=1, digit 2 resumes with the remaining phase count unchanged. A strobe during en=0 still lands in buf[0].
- Back-to-back strobes: strobes on 3 consecutive cycles (8'h3F, 8'h06, 8'h5B) → buf[2..0] = 3F, 06, 5B.
- Dim (SEG_SCAN_DIM_EN defined, DRIVE_CYC=16): bright=3 → dig_sel high for 4 of 16 DRIVE cycles. bright=15 → high for all 16 cycles.
